// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - calendar field encodings, month constants and month-length lookup
package calendar_pkg;

    typedef enum logic [1:0] {
        FIELD_DAY     = 2'd0,
        FIELD_MONTH   = 2'd1,
        FIELD_YEAR    = 2'd2,
        FIELD_WEEKDAY = 2'd3
    } field_e;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_APR = 4'd4;
    localparam logic [3:0] MONTH_JUN = 4'd6;
    localparam logic [3:0] MONTH_SEP = 4'd9;
    localparam logic [3:0] MONTH_NOV = 4'd11;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    localparam logic [6:0] YEAR_MAX    = 7'd99;
    localparam logic [2:0] WEEKDAY_MAX = 3'd6;

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] dim;
        case (month)
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: dim = 5'd30;
            MONTH_FEB: dim = leap ? 5'd29 : 5'd28;
            default:   dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/binary_to_bcd_8bit.sv
// rtl/binary_to_bcd_8bit.sv - two-digit BCD conversion of a binary value 0..99
module binary_to_bcd_8bit (
    input  logic [7:0] bin_i,
    output logic [7:0] bcd_o
);
    // Tens digit lands in the upper nibble; inputs above 99 are never presented.
    assign bcd_o = ((bin_i / 8'd10) << 4) | (bin_i % 8'd10);
endmodule

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - rising-edge detector; prev resets high so a level held through reset is not an edge
module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/date_counter.sv
// rtl/date_counter.sv - day/month/year/weekday calendar advanced by the hour carry, with manual set mode
module date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_RESET    = 0,
    parameter int MONTH_RESET   = 1,
    parameter int DAY_RESET     = 1,
    parameter int WEEKDAY_RESET = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hour_carry,
    input  logic       set,
    input  logic [1:0] set_field,
    input  logic       set_inc,
    output logic [7:0] day_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic [2:0] weekday,
    output logic       leap,
    output logic       year_carry
);
    logic [4:0] day_q, day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic [2:0] wd_q, wd_d;
    logic       yc_q, yc_d;
    logic       carry_rise, inc_rise;
    logic [4:0] dim_cur, dim_new;

    edge_rise u_carry_edge (.clock(clock), .reset(reset), .level_i(hour_carry), .rise_o(carry_rise));
    edge_rise u_inc_edge   (.clock(clock), .reset(reset), .level_i(set_inc),    .rise_o(inc_rise));

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        wd_d    = wd_q;
        yc_d    = 1'b0;
        dim_cur = days_in_month(month_q, year_q[1:0] == 2'b00);

        if (!set && carry_rise) begin
            wd_d = (wd_q == WEEKDAY_MAX) ? 3'd0 : wd_q + 3'd1;
            if (day_q < dim_cur) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q == MONTH_DEC) begin
                    month_d = MONTH_JAN;
                    if (year_q == YEAR_MAX) begin
                        year_d = 7'd0;
                        yc_d   = 1'b1;
                    end else begin
                        year_d = year_q + 7'd1;
                    end
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else if (set && inc_rise) begin
            case (field_e'(set_field))
                FIELD_DAY:     day_d   = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                FIELD_MONTH:   month_d = (month_q == MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
                FIELD_YEAR:    year_d  = (year_q == YEAR_MAX) ? 7'd0 : year_q + 7'd1;
                FIELD_WEEKDAY: wd_d    = (wd_q == WEEKDAY_MAX) ? 3'd0 : wd_q + 3'd1;
                default:       ;
            endcase
        end

        // Clamp after the increment so a shorter new month never leaves an invalid day.
        dim_new = days_in_month(month_d, year_d[1:0] == 2'b00);
        if (day_d > dim_new) day_d = dim_new;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            day_q   <= 5'(DAY_RESET);
            month_q <= 4'(MONTH_RESET);
            year_q  <= 7'(YEAR_RESET);
            wd_q    <= 3'(WEEKDAY_RESET);
            yc_q    <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wd_q    <= wd_d;
            yc_q    <= yc_d;
        end
    end

    binary_to_bcd_8bit u_day_bcd   (.bin_i({3'b000, day_q}),  .bcd_o(day_bcd));
    binary_to_bcd_8bit u_month_bcd (.bin_i({4'b0000, month_q}), .bcd_o(month_bcd));
    binary_to_bcd_8bit u_year_bcd  (.bin_i({1'b0, year_q}),   .bcd_o(year_bcd));

    assign weekday    = wd_q;
    assign leap       = (year_q[1:0] == 2'b00);
    assign year_carry = yc_q;
endmodule

// File: tb/tb_date_counter.sv
// tb/tb_date_counter.sv - directed vector bench for date_counter
module tb_date_counter;
    logic       clock = 1'b0;
    logic       reset, hour_carry, set, set_inc;
    logic [1:0] set_field;
    logic [7:0] day_bcd, month_bcd, year_bcd;
    logic [2:0] weekday;
    logic       leap, year_carry;

    int n_cmp = 0;
    int n_bad = 0;
    int yc_seen = 0;

    date_counter dut (
        .clock(clock), .reset(reset), .hour_carry(hour_carry), .set(set),
        .set_field(set_field), .set_inc(set_inc), .day_bcd(day_bcd),
        .month_bcd(month_bcd), .year_bcd(year_bcd), .weekday(weekday),
        .leap(leap), .year_carry(year_carry)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       set_v;
        logic       use_inc;
        logic [1:0] fld;
        logic [7:0] n;
        logic [7:0] e_day;
        logic [7:0] e_mon;
        logic [7:0] e_yr;
        logic [2:0] e_wd;
        logic       e_leap;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] d, input logic [7:0] m,
                             input logic [7:0] y, input logic [2:0] w, input logic l);
        chk({tag, "_day"}, day_bcd, d);
        chk({tag, "_month"}, month_bcd, m);
        chk({tag, "_year"}, year_bcd, y);
        chk({tag, "_weekday"}, {5'd0, weekday}, {5'd0, w});
        chk({tag, "_leap"}, {7'd0, leap}, {7'd0, l});
    endtask

    task automatic pulse(input logic use_inc);
        @(negedge clock);
        if (use_inc) set_inc = 1'b1; else hour_carry = 1'b1;
        @(negedge clock);
        if (year_carry) yc_seen++;
        set_inc = 1'b0;
        hour_carry = 1'b0;
        @(negedge clock);
        if (year_carry) yc_seen++;
    endtask

    task automatic pulses(input logic [1:0] fld, input int n);
        set_field = fld;
        for (int k = 0; k < n; k++) pulse(1'b1);
    endtask

    initial begin
        //             set  inc  fld    n      day    mon    yr     wd    leap
        vt[0]  = '{1'b1, 1'b1, 2'd2, 8'd1,  8'h01, 8'h01, 8'h01, 3'd6, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 2'd1, 8'd1,  8'h01, 8'h02, 8'h01, 3'd6, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 2'd0, 8'd27, 8'h28, 8'h02, 8'h01, 3'd6, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 8'd1,  8'h01, 8'h03, 8'h01, 3'd0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 2'd1, 8'd11, 8'h01, 8'h02, 8'h01, 3'd0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 2'd2, 8'd3,  8'h01, 8'h02, 8'h04, 3'd0, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 2'd0, 8'd27, 8'h28, 8'h02, 8'h04, 3'd0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 8'd1,  8'h29, 8'h02, 8'h04, 3'd1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 8'd1,  8'h01, 8'h03, 8'h04, 3'd2, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 2'd1, 8'd10, 8'h01, 8'h01, 8'h04, 3'd2, 1'b1};
        vt[10] = '{1'b1, 1'b1, 2'd0, 8'd30, 8'h31, 8'h01, 8'h04, 3'd2, 1'b1};
        vt[11] = '{1'b1, 1'b1, 2'd1, 8'd1,  8'h29, 8'h02, 8'h04, 3'd2, 1'b1};
        vt[12] = '{1'b1, 1'b1, 2'd1, 8'd1,  8'h29, 8'h03, 8'h04, 3'd2, 1'b1};
        vt[13] = '{1'b1, 1'b1, 2'd0, 8'd3,  8'h01, 8'h03, 8'h04, 3'd2, 1'b1};
        vt[14] = '{1'b1, 1'b1, 2'd3, 8'd5,  8'h01, 8'h03, 8'h04, 3'd0, 1'b1};
        vt[15] = '{1'b1, 1'b1, 2'd1, 8'd11, 8'h01, 8'h02, 8'h04, 3'd0, 1'b1};
        vt[16] = '{1'b1, 1'b1, 2'd0, 8'd28, 8'h29, 8'h02, 8'h04, 3'd0, 1'b1};
        vt[17] = '{1'b1, 1'b1, 2'd2, 8'd1,  8'h28, 8'h02, 8'h05, 3'd0, 1'b0};
        vt[18] = '{1'b1, 1'b1, 2'd0, 8'd1,  8'h01, 8'h02, 8'h05, 3'd0, 1'b0};
        vt[19] = '{1'b1, 1'b0, 2'd0, 8'd5,  8'h01, 8'h02, 8'h05, 3'd0, 1'b0};
        vt[20] = '{1'b0, 1'b1, 2'd0, 8'd3,  8'h01, 8'h02, 8'h05, 3'd0, 1'b0};
        vt[21] = '{1'b0, 1'b0, 2'd0, 8'd1,  8'h02, 8'h02, 8'h05, 3'd1, 1'b0};

        reset = 1'b1; hour_carry = 1'b1; set = 1'b0; set_inc = 1'b0; set_field = 2'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk_state("reset_hold", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);
        chk("reset_hold_yc", {7'd0, year_carry}, 8'd0);
        hour_carry = 1'b0;
        @(negedge clock);
        chk_state("carry_fall", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);

        for (int i = 0; i < 22; i++) begin
            set = vt[i].set_v;
            yc_seen = 0;
            if (vt[i].use_inc) pulses(vt[i].fld, int'(vt[i].n));
            else for (int k = 0; k < int'(vt[i].n); k++) pulse(1'b0);
            chk_state($sformatf("vec%0d", i), vt[i].e_day, vt[i].e_mon, vt[i].e_yr, vt[i].e_wd, vt[i].e_leap);
            chk($sformatf("vec%0d_yc", i), 8'(yc_seen), 8'd0);
        end

        set = 1'b1; yc_seen = 0;
        pulses(2'd2, 94);
        chk_state("set_y99", 8'h02, 8'h02, 8'h99, 3'd1, 1'b0);
        pulses(2'd2, 1);
        chk_state("set_ywrap", 8'h02, 8'h02, 8'h00, 3'd1, 1'b1);
        chk("set_ywrap_yc", 8'(yc_seen), 8'd0);
        pulses(2'd0, 2);
        chk_state("pre_reset", 8'h04, 8'h02, 8'h00, 3'd1, 1'b1);
        @(negedge clock);
        set_inc = 1'b1; reset = 1'b1;
        @(negedge clock);
        chk_state("mid_reset", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        chk_state("reset_release_inc_high", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);
        set_inc = 1'b0;

        pulses(2'd2, 99);
        pulses(2'd1, 11);
        pulses(2'd0, 30);
        pulses(2'd3, 6);
        chk_state("eoc_setup", 8'h31, 8'h12, 8'h99, 3'd5, 1'b0);
        set = 1'b0;
        @(negedge clock);
        hour_carry = 1'b1;
        @(negedge clock);
        chk("eoc_yc_high", {7'd0, year_carry}, 8'd1);
        chk_state("eoc_rollover", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);
        hour_carry = 1'b0;
        @(negedge clock);
        chk("eoc_yc_low", {7'd0, year_carry}, 8'd0);
        @(negedge clock);
        chk("eoc_yc_low2", {7'd0, year_carry}, 8'd0);
        chk_state("eoc_hold", 8'h01, 8'h01, 8'h00, 3'd6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
